pipe_flow_ctrl_n: RTL and testbench

- Parametrised next-generation pipeline flow controller: stall, bubble, flush and redirect for an N-stage in-order core.
- Serves any number of cache-miss channels (I/D and future) and redirect sources (jump, branch, trap).
- Replaces level-only stall flags with registered per-channel miss FSMs, with abort-on-redirect, a stall watchdog and a stall perf counter.
- Sits beside the pipeline registers; drives pc, stage holds and inter-stage registers.

---
 rtl/pipe_flow_ctrl_n.sv | 156 +++++++++++++++
 tb/tb_pipe_flow_ctrl_n.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_flow_ctrl_n.sv
// Stall/bubble/flush/redirect controller for an N-stage in-order core.
// Zero latency: all controls are combinational from registered FSM state; misses stall stages 0..H_c upstream.
module pipe_flow_ctrl_n #(
  parameter int STAGES = 5,
  parameter int NUM_CH = 2,
  parameter int NUM_RD = 2,
  parameter logic [3*NUM_CH-1:0] CH_STAGE = {3'd3, 3'd0},
  parameter logic [3*NUM_CH-1:0] CH_HOLD  = {3'd4, 3'd1},
  parameter logic [3*NUM_RD-1:0] RD_STAGE = {3'd2, 3'd1},
  parameter int TIMEOUT = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_RD-1:0]    rd_flag_i,
  input  logic [32*NUM_RD-1:0] rd_pc_i,
  input  logic [NUM_CH-1:0]    miss_req_i,
  input  logic [NUM_CH-1:0]    miss_hit_i,
  input  logic [NUM_CH-1:0]    miss_ready_i,
  output logic [NUM_CH-1:0]    data_valid_o,
  output logic                 redirect_flag_o,
  output logic [31:0]          redirect_pc_o,
  output logic [STAGES-1:0]    hold_stage_o,
  output logic [STAGES-2:0]    hold_reg_o,
  output logic [STAGES-2:0]    flush_reg_o,
  output logic                 stall_timeout_o,
  output logic [31:0]          perf_stall_cnt_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_MISS, ST_ABORT} ch_state_t;

  localparam logic [7:0] TO8 = 8'(TIMEOUT);

  function automatic int ch_s(input int c);
    return int'(CH_STAGE[3*c +: 3]);
  endfunction

  function automatic int ch_h(input int c);
    return int'(CH_HOLD[3*c +: 3]);
  endfunction

  function automatic int rd_s(input int r);
    return int'(RD_STAGE[3*r +: 3]);
  endfunction

  ch_state_t          state_q [NUM_CH];
  logic [NUM_CH-1:0]  ready_q;
  logic [7:0]         wd_cnt_q;
  logic               timeout_q;
  logic [31:0]        perf_q;

  logic [NUM_CH-1:0]  rise, cand, aborted, active, in_abort, dv;
  logic [NUM_RD-1:0]  blocked;
  logic               rd_acc;
  int                 rd_stage_w;
  logic [31:0]        rd_pc_w;
  logic [STAGES-1:0]  hs;
  logic [STAGES-2:0]  hr_raw, bub, rfl;
  logic               any_busy;

  always_comb begin
    rise = miss_ready_i & ~ready_q;
    any_busy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      cand[c] = (state_q[c] == ST_MISS) ||
                ((state_q[c] == ST_IDLE) && miss_req_i[c] && !miss_hit_i[c]);
      if (state_q[c] != ST_IDLE) any_busy = 1'b1;
    end

    // A stalled stage at or below a source keeps that source's redirect pending.
    for (int r = 0; r < NUM_RD; r++) begin
      blocked[r] = 1'b0;
      for (int c = 0; c < NUM_CH; c++)
        if (cand[c] && ch_s(c) >= rd_s(r)) blocked[r] = 1'b1;
    end

    rd_acc = 1'b0;
    rd_stage_w = 0;
    rd_pc_w = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (rd_flag_i[r] && !blocked[r] && (!rd_acc || rd_s(r) > rd_stage_w)) begin
        rd_acc = 1'b1;
        rd_stage_w = rd_s(r);
        rd_pc_w = rd_pc_i[32*r +: 32];
      end
    end

    // A miss younger than the accepted redirect is killed in the same cycle:
    // it stops stalling and behaves as an abort from now on.
    for (int c = 0; c < NUM_CH; c++) begin
      aborted[c]  = rd_acc && (rd_stage_w > ch_s(c));
      active[c]   = cand[c] && !aborted[c];
      in_abort[c] = (state_q[c] == ST_ABORT) || (cand[c] && aborted[c]);
      dv[c]       = (state_q[c] == ST_MISS) && rise[c] && !aborted[c];
    end

    hs = '0;
    hr_raw = '0;
    bub = '0;
    rfl = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < STAGES; k++) begin
        if (active[c] && k <= ch_h(c)) hs[k] = 1'b1;
        if (in_abort[c] && k <= ch_s(c)) hs[k] = 1'b1;
      end
      for (int k = 0; k < STAGES-1; k++) begin
        if (active[c] && k < ch_h(c)) hr_raw[k] = 1'b1;
        if (active[c] && k == ch_h(c)) bub[k] = 1'b1;
      end
    end
    for (int k = 0; k < STAGES-1; k++)
      if (rd_acc && k < rd_stage_w) rfl[k] = 1'b1;
    if (rd_acc) hs[0] = 1'b0;
  end

  assign data_valid_o     = rst_n ? dv : '0;
  assign redirect_flag_o  = rst_n & rd_acc;
  assign redirect_pc_o    = (rst_n && rd_acc) ? rd_pc_w : 32'd0;
  assign hold_stage_o     = rst_n ? hs : '0;
  assign hold_reg_o       = rst_n ? (hr_raw & ~rfl) : '0;
  assign flush_reg_o      = rst_n ? (rfl | (bub & ~hr_raw)) : '0;
  assign stall_timeout_o  = timeout_q;
  assign perf_stall_cnt_o = perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= '0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
      perf_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= ST_IDLE;
    end else begin
      ready_q <= miss_ready_i;
      for (int c = 0; c < NUM_CH; c++) begin
        case (state_q[c])
          ST_IDLE:  if (active[c]) state_q[c] <= ST_MISS;
          ST_MISS: begin
            if (aborted[c])   state_q[c] <= rise[c] ? ST_IDLE : ST_ABORT;
            else if (rise[c]) state_q[c] <= ST_IDLE;
          end
          ST_ABORT: if (rise[c]) state_q[c] <= ST_IDLE;
          default:  state_q[c] <= ST_IDLE;
        endcase
      end

      if (any_busy) begin
        if (wd_cnt_q != 8'hFF) wd_cnt_q <= wd_cnt_q + 8'd1;
        if (({1'b0, wd_cnt_q} + 9'd1) >= {1'b0, TO8}) timeout_q <= 1'b1;
      end else begin
        wd_cnt_q <= '0;
      end

      if (hs[0]) perf_q <= perf_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_flow_ctrl_n.sv
// Directed bench for pipe_flow_ctrl_n: cycle table plus watchdog and reset sequences.
module tb_pipe_flow_ctrl_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rd_flag_i = '0;
  logic [63:0] rd_pc_i = '0;
  logic [1:0]  miss_req_i = '0;
  logic [1:0]  miss_hit_i = '0;
  logic [1:0]  miss_ready_i = '0;
  logic [1:0]  data_valid_o;
  logic        redirect_flag_o;
  logic [31:0] redirect_pc_o;
  logic [4:0]  hold_stage_o;
  logic [3:0]  hold_reg_o;
  logic [3:0]  flush_reg_o;
  logic        stall_timeout_o;
  logic [31:0] perf_stall_cnt_o;

  int checks = 0;
  int errors = 0;
  int perf_exp = 0;

  pipe_flow_ctrl_n dut (
    .clk(clk), .rst_n(rst_n),
    .rd_flag_i(rd_flag_i), .rd_pc_i(rd_pc_i),
    .miss_req_i(miss_req_i), .miss_hit_i(miss_hit_i), .miss_ready_i(miss_ready_i),
    .data_valid_o(data_valid_o), .redirect_flag_o(redirect_flag_o),
    .redirect_pc_o(redirect_pc_o), .hold_stage_o(hold_stage_o),
    .hold_reg_o(hold_reg_o), .flush_reg_o(flush_reg_o),
    .stall_timeout_o(stall_timeout_o), .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req, hit, rdy, rdf;
    logic [31:0] pc0, pc1;
    logic [1:0]  dv;
    logic        rf;
    logic [31:0] rpc;
    logic [4:0]  hs;
    logic [3:0]  hr, fr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [1:0] req, hit, rdy, rdf,
                              input logic [31:0] pc0, pc1,
                              input logic [1:0] dv, input logic rf,
                              input logic [31:0] rpc, input logic [4:0] hs,
                              input logic [3:0] hr, fr);
    vec_t v;
    v.req = req; v.hit = hit; v.rdy = rdy; v.rdf = rdf;
    v.pc0 = pc0; v.pc1 = pc1; v.dv = dv; v.rf = rf; v.rpc = rpc;
    v.hs = hs; v.hr = hr; v.fr = fr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // req hit rdy rdf pc0 pc1 | dv rf rpc hs hr fr
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00000,4'b0000,4'b0000));
    vt.push_back(mk(2'b01,2'b01,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00000,4'b0000,4'b0000));
    // I miss, ready rises six cycles later
    vt.push_back(mk(2'b01,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00011,4'b0001,4'b0010));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00011,4'b0001,4'b0010));
    vt.push_back(mk(2'b01,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00011,4'b0001,4'b0010));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00011,4'b0001,4'b0010));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00011,4'b0001,4'b0010));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00011,4'b0001,4'b0010));
    vt.push_back(mk(2'b00,2'b00,2'b01,2'b00,0,0,         2'b01,0,0,     5'b00011,4'b0001,4'b0010));
    vt.push_back(mk(2'b00,2'b00,2'b01,2'b00,0,0,         2'b00,0,0,     5'b00000,4'b0000,4'b0000));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00000,4'b0000,4'b0000));
    // D miss with a pending branch
    vt.push_back(mk(2'b10,2'b00,2'b00,2'b10,0,32'h80,    2'b00,0,0,     5'b11111,4'b1111,4'b0000));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b10,0,32'h80,    2'b00,0,0,     5'b11111,4'b1111,4'b0000));
    vt.push_back(mk(2'b00,2'b00,2'b10,2'b10,0,32'h80,    2'b10,0,0,     5'b11111,4'b1111,4'b0000));
    vt.push_back(mk(2'b00,2'b00,2'b10,2'b10,0,32'h80,    2'b00,1,32'h80,5'b00000,4'b0000,4'b0011));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00000,4'b0000,4'b0000));
    // simultaneous redirects, then jump alone
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b11,32'h40,32'h80,2'b00,1,32'h80,5'b00000,4'b0000,4'b0011));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b01,32'h40,0,    2'b00,1,32'h40,5'b00000,4'b0000,4'b0001));
    // I miss aborted by a jump
    vt.push_back(mk(2'b01,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00011,4'b0001,4'b0010));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b01,32'h100,0,   2'b00,1,32'h100,5'b00000,4'b0000,4'b0001));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00001,4'b0000,4'b0000));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00001,4'b0000,4'b0000));
    vt.push_back(mk(2'b00,2'b00,2'b01,2'b00,0,0,         2'b00,0,0,     5'b00001,4'b0000,4'b0000));
    vt.push_back(mk(2'b00,2'b00,2'b01,2'b00,0,0,         2'b00,0,0,     5'b00000,4'b0000,4'b0000));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00000,4'b0000,4'b0000));
    // miss request dropped by a same-cycle jump
    vt.push_back(mk(2'b01,2'b00,2'b00,2'b01,32'h200,0,   2'b00,1,32'h200,5'b00000,4'b0000,4'b0001));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00000,4'b0000,4'b0000));
    // both channels miss; jump blocked by D; D hold beats I bubble
    vt.push_back(mk(2'b11,2'b00,2'b00,2'b01,32'h300,0,   2'b00,0,0,     5'b11111,4'b1111,4'b0000));
    vt.push_back(mk(2'b00,2'b00,2'b11,2'b00,0,0,         2'b11,0,0,     5'b11111,4'b1111,4'b0000));
    vt.push_back(mk(2'b00,2'b00,2'b11,2'b00,0,0,         2'b00,0,0,     5'b00000,4'b0000,4'b0000));
    vt.push_back(mk(2'b00,2'b00,2'b00,2'b00,0,0,         2'b00,0,0,     5'b00000,4'b0000,4'b0000));

    // reset: outputs forced low even with requests driven
    miss_req_i = 2'b11; rd_flag_i = 2'b11; rd_pc_i = {32'h80, 32'h40};
    @(negedge clk);
    chk("rst_dv", 32'(data_valid_o), 0);
    chk("rst_rf", 32'(redirect_flag_o), 0);
    chk("rst_rpc", redirect_pc_o, 0);
    chk("rst_hs", 32'(hold_stage_o), 0);
    chk("rst_hr", 32'(hold_reg_o), 0);
    chk("rst_fr", 32'(flush_reg_o), 0);
    chk("rst_to", 32'(stall_timeout_o), 0);
    chk("rst_perf", perf_stall_cnt_o, 0);
    next_cycle();
    miss_req_i = '0; rd_flag_i = '0; rd_pc_i = '0;
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      miss_req_i = vt[i].req; miss_hit_i = vt[i].hit; miss_ready_i = vt[i].rdy;
      rd_flag_i = vt[i].rdf; rd_pc_i = {vt[i].pc1, vt[i].pc0};
      @(negedge clk);
      chk($sformatf("v%0d_dv", i), 32'(data_valid_o), 32'(vt[i].dv));
      chk($sformatf("v%0d_rf", i), 32'(redirect_flag_o), 32'(vt[i].rf));
      chk($sformatf("v%0d_rpc", i), redirect_pc_o, vt[i].rpc);
      chk($sformatf("v%0d_hs", i), 32'(hold_stage_o), 32'(vt[i].hs));
      chk($sformatf("v%0d_hr", i), 32'(hold_reg_o), 32'(vt[i].hr));
      chk($sformatf("v%0d_fr", i), 32'(flush_reg_o), 32'(vt[i].fr));
      if (vt[i].hs[0]) perf_exp++;
      next_cycle();
    end
    chk("table_perf", perf_stall_cnt_o, 32'(perf_exp));
    chk("table_to", 32'(stall_timeout_o), 0);

    // watchdog: I miss that never gets ready
    miss_req_i = 2'b01; miss_hit_i = '0; miss_ready_i = '0; rd_flag_i = '0; rd_pc_i = '0;
    @(negedge clk);
    chk("wd_start_hs", 32'(hold_stage_o), 32'b00011);
    next_cycle();
    miss_req_i = '0;
    for (int i = 1; i <= 201; i++) begin
      @(negedge clk);
      if (i == 200) chk("wd_cycle200", 32'(stall_timeout_o), 0);
      if (i == 201) chk("wd_cycle201", 32'(stall_timeout_o), 1);
      next_cycle();
    end
    miss_ready_i = 2'b01;
    @(negedge clk);
    chk("wd_resolve_dv", 32'(data_valid_o), 32'b01);
    next_cycle();
    @(negedge clk);
    chk("wd_idle_hs", 32'(hold_stage_o), 0);
    chk("wd_sticky", 32'(stall_timeout_o), 1);
    chk("wd_perf", perf_stall_cnt_o, 32'(perf_exp + 203));
    next_cycle();

    // reset in the middle of a miss, ready high across deassert
    miss_ready_i = '0;
    next_cycle();
    miss_req_i = 2'b01;
    next_cycle();
    miss_req_i = '0;
    @(negedge clk);
    chk("rm_miss_hs", 32'(hold_stage_o), 32'b00011);
    next_cycle();
    rst_n = 1'b0;
    miss_ready_i = 2'b01;
    @(negedge clk);
    chk("rm_dv", 32'(data_valid_o), 0);
    chk("rm_hs", 32'(hold_stage_o), 0);
    chk("rm_hr", 32'(hold_reg_o), 0);
    chk("rm_fr", 32'(flush_reg_o), 0);
    chk("rm_to", 32'(stall_timeout_o), 0);
    chk("rm_perf", perf_stall_cnt_o, 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rm_post_dv", 32'(data_valid_o), 0);
    chk("rm_post_hs", 32'(hold_stage_o), 0);
    next_cycle();
    @(negedge clk);
    chk("rm_post2_dv", 32'(data_valid_o), 0);
    chk("rm_post2_perf", perf_stall_cnt_o, 0);
    chk("rm_post2_to", 32'(stall_timeout_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
